// File: rtl/dmem_responder.sv
// dmem_responder: data-side bus target for a single-cycle core.
// Holds a word-addressed RAM plus a small register block (cycle counter,
// RAM read/write counters, sticky error status, LED register).
// Reads are combinational. Writes and register updates commit on the
// rising clock edge.
//
// Ports:
//   clk      system clock, rising edge
//   reset    synchronous active-high reset (RAM contents are kept)
//   DM_CS    chip select
//   DM_R     read request
//   DM_W     write request (wins over DM_R for counting purposes)
//   maddr    byte address
//   mwdata   write data
//   mrdata   combinational read data, 0 when nothing valid is addressed
//   err      OR of the sticky error bits
//   led_out  LED register
module dmem_responder #(
  parameter int unsigned ADDR_W    = 10,
  parameter logic [31:0] MMIO_BASE = 32'h0000_8000
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        DM_CS,
  input  logic        DM_R,
  input  logic        DM_W,
  input  logic [31:0] maddr,
  input  logic [31:0] mwdata,
  output logic [31:0] mrdata,
  output logic        err,
  output logic [7:0]  led_out
);

  localparam int unsigned DEPTH = 2 ** ADDR_W;

  // Register indices into mmio_sel (offset / 4).
  localparam int R_CYCLE  = 0;
  localparam int R_RDCNT  = 1;
  localparam int R_WRCNT  = 2;
  localparam int R_STATUS = 3;
  localparam int R_LED    = 4;

  logic [31:0] mem_q [DEPTH];

  logic [31:0] cycle_q, cycle_d;
  logic [31:0] rdcnt_q, rdcnt_d;
  logic [31:0] wrcnt_q, wrcnt_d;
  logic [1:0]  status_q, status_d;
  logic [7:0]  led_q, led_d;

  logic              acc, wr, rd;
  logic              mis, ram_hit, mmio_hit, oor;
  logic [4:0]        mmio_sel;
  logic [ADDR_W-1:0] widx;

  // ---------------------------------------------------------------- decode
  assign acc  = DM_CS & (DM_R | DM_W);
  assign wr   = acc & DM_W;
  assign rd   = acc & DM_R & ~DM_W;
  assign widx = maddr[ADDR_W+1:2];
  assign mis  = maddr[1:0] != 2'b00;

  // RAM covers every address whose bits above the word index are zero.
  assign ram_hit = !mis && ((maddr >> (ADDR_W + 2)) == 32'd0);

  always_comb begin
    mmio_sel = '0;
    for (int k = 0; k < 5; k++)
      mmio_sel[k] = !mis && (maddr == MMIO_BASE + 32'(4 * k));
  end

  assign mmio_hit = |mmio_sel;
  assign oor      = !mis && !ram_hit && !mmio_hit;

  // ------------------------------------------------------------- read path
  // Reflects current state, so a simultaneous write is read-before-write.
  always_comb begin
    mrdata = '0;
    if (DM_CS && DM_R) begin
      if (ram_hit)                mrdata = mem_q[widx];
      else if (mmio_sel[R_CYCLE]) mrdata = cycle_q;
      else if (mmio_sel[R_RDCNT]) mrdata = rdcnt_q;
      else if (mmio_sel[R_WRCNT]) mrdata = wrcnt_q;
      else if (mmio_sel[R_STATUS]) mrdata = {30'd0, status_q};
      else if (mmio_sel[R_LED])   mrdata = {24'd0, led_q};
    end
  end

  // ------------------------------------------------------------ next state
  always_comb begin
    cycle_d  = cycle_q + 32'd1;
    rdcnt_d  = rdcnt_q;
    wrcnt_d  = wrcnt_q;
    status_d = status_q;
    led_d    = led_q;

    if (rd && ram_hit && rdcnt_q != '1) rdcnt_d = rdcnt_q + 32'd1;
    if (wr && ram_hit && wrcnt_q != '1) wrcnt_d = wrcnt_q + 32'd1;

    if (wr && mmio_sel[R_STATUS]) status_d = status_q & ~mwdata[1:0];
    if (wr && mmio_sel[R_LED])    led_d    = mwdata[7:0];

    // A faulting access cannot also address STATUS, so no clear/set race.
    if (acc && mis) status_d[0] = 1'b1;
    if (acc && oor) status_d[1] = 1'b1;
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      cycle_q  <= '0;
      rdcnt_q  <= '0;
      wrcnt_q  <= '0;
      status_q <= '0;
      led_q    <= '0;
    end else begin
      cycle_q  <= cycle_d;
      rdcnt_q  <= rdcnt_d;
      wrcnt_q  <= wrcnt_d;
      status_q <= status_d;
      led_q    <= led_d;
    end
  end

  // RAM has no reset; reset only blocks the write.
  always_ff @(posedge clk) begin
    if (!reset && wr && ram_hit) mem_q[widx] <= mwdata;
  end

  assign err     = |status_q;
  assign led_out = led_q;

endmodule

// File: tb/tb_dmem_responder.sv
module tb_dmem_responder;

  localparam int unsigned ADDR_W    = 10;
  localparam logic [31:0] MMIO_BASE = 32'h0000_8000;
  localparam logic [31:0] RAM_END   = 32'd4 * (32'd1 << ADDR_W);
  localparam logic [31:0] A_CYCLE   = MMIO_BASE + 32'h0;
  localparam logic [31:0] A_RDCNT   = MMIO_BASE + 32'h4;
  localparam logic [31:0] A_WRCNT   = MMIO_BASE + 32'h8;
  localparam logic [31:0] A_STATUS  = MMIO_BASE + 32'hC;
  localparam logic [31:0] A_LED     = MMIO_BASE + 32'h10;

  logic        clk, reset;
  logic        DM_CS, DM_R, DM_W;
  logic [31:0] maddr, mwdata, mrdata;
  logic        err;
  logic [7:0]  led_out;

  int total = 0;
  int bad   = 0;
  logic [31:0] exp_q [$];
  logic [31:0] c1, c2, dummy;

  dmem_responder #(.ADDR_W(ADDR_W), .MMIO_BASE(MMIO_BASE)) dut (
    .clk(clk), .reset(reset),
    .DM_CS(DM_CS), .DM_R(DM_R), .DM_W(DM_W),
    .maddr(maddr), .mwdata(mwdata), .mrdata(mrdata),
    .err(err), .led_out(led_out)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s: got=%h exp=%h", tag, got, exp);
    end
  endtask

  // One bus cycle: drive at negedge, check mrdata against the scoreboard
  // before the edge, release the bus just after the edge.
  task automatic bus(input string tag, input logic cs, r, w,
                     input logic [31:0] a, d, exp, input bit sc,
                     output logic [31:0] got);
    @(negedge clk);
    DM_CS = cs; DM_R = r; DM_W = w; maddr = a; mwdata = d;
    if (sc) exp_q.push_back(exp);
    #2;
    got = mrdata;
    if (sc) chk(tag, mrdata, exp_q.pop_front());
    @(posedge clk);
    #1;
    DM_CS = 1'b0; DM_R = 1'b0; DM_W = 1'b0;
  endtask

  task automatic rd(input string tag, input logic [31:0] a, input logic [31:0] exp);
    logic [31:0] g;
    bus(tag, 1'b1, 1'b1, 1'b0, a, 32'h0, exp, 1'b1, g);
  endtask

  // Write-only cycles must return zero on mrdata.
  task automatic wr(input string tag, input logic [31:0] a, input logic [31:0] d);
    logic [31:0] g;
    bus(tag, 1'b1, 1'b0, 1'b1, a, d, 32'h0, 1'b1, g);
  endtask

  initial begin
    reset = 1'b1; DM_CS = 1'b0; DM_R = 1'b0; DM_W = 1'b0;
    maddr = '0; mwdata = '0;
    repeat (2) @(posedge clk);
    #1;
    chk("rst_led", {24'd0, led_out}, 32'h0);
    chk("rst_err", {31'd0, err}, 32'h0);
    reset = 1'b0;

    // CYCLE is 0 in the first cycle out of reset
    rd("cycle_first", A_CYCLE, 32'h0);
    rd("rdcnt_rst", A_RDCNT, 32'h0);
    rd("wrcnt_rst", A_WRCNT, 32'h0);
    rd("status_rst", A_STATUS, 32'h0);

    // RAM basic
    wr("w10", 32'h10, 32'hDEAD_BEEF);
    rd("r10", 32'h10, 32'hDEAD_BEEF);
    rd("wrcnt1", A_WRCNT, 32'd1);
    rd("rdcnt1", A_RDCNT, 32'd1);

    // CS low: no read data, no effect
    bus("cs_low", 1'b0, 1'b1, 1'b1, 32'h10, 32'h0BAD_0BAD, 32'h0, 1'b1, dummy);
    rd("r10_cs", 32'h10, 32'hDEAD_BEEF);          // rdcnt 2

    // Top RAM word boundary
    wr("w_top", RAM_END - 32'd4, 32'hA5A5_5A5A);   // wrcnt 2
    rd("r_top", RAM_END - 32'd4, 32'hA5A5_5A5A);   // rdcnt 3

    // Read-before-write
    wr("w20", 32'h20, 32'h1111_1111);              // wrcnt 3
    bus("rbw", 1'b1, 1'b1, 1'b1, 32'h20, 32'h2222_2222, 32'h1111_1111, 1'b1, dummy); // wrcnt 4
    rd("r20", 32'h20, 32'h2222_2222);              // rdcnt 4
    rd("rdcnt_rbw", A_RDCNT, 32'd4);
    rd("wrcnt_rbw", A_WRCNT, 32'd4);

    // Misaligned
    wr("w_mis", 32'h13, 32'hFFFF_0000);
    chk("err_mis", {31'd0, err}, 32'h1);
    rd("r10_mis", 32'h10, 32'hDEAD_BEEF);          // rdcnt 5
    rd("status_mis", A_STATUS, 32'h1);
    rd("wrcnt_mis", A_WRCNT, 32'd4);
    wr("clr_mis", A_STATUS, 32'h1);
    chk("err_clr", {31'd0, err}, 32'h0);

    // Out-of-range
    rd("r_oor", RAM_END, 32'h0);
    rd("status_oor", A_STATUS, 32'h2);
    rd("rdcnt_oor", A_RDCNT, 32'd5);
    wr("clr_oor", A_STATUS, 32'h2);
    wr("w_rdcnt", A_RDCNT, 32'hFF);
    rd("rdcnt_ro", A_RDCNT, 32'd5);
    rd("status_ro", A_STATUS, 32'h0);
    rd("r_gap", MMIO_BASE + 32'h14, 32'h0);        // just past the map
    rd("status_gap", A_STATUS, 32'h2);
    wr("clr_gap", A_STATUS, 32'h3);
    chk("err_gap", {31'd0, err}, 32'h0);

    // LED and CYCLE
    wr("w_led", A_LED, 32'h1A5);
    chk("led_out", {24'd0, led_out}, 32'hA5);
    rd("r_led", A_LED, 32'h0000_00A5);
    bus("cyc_a", 1'b1, 1'b1, 1'b0, A_CYCLE, 32'h0, 32'h0, 1'b0, c1);
    bus("cyc_b", 1'b1, 1'b1, 1'b0, A_CYCLE, 32'h0, 32'h0, 1'b0, c2);
    chk("cyc_diff", c2 - c1, 32'd1);

    // Reset mid-operation
    wr("w40", 32'h40, 32'h1234_5678);
    wr("w_mis2", 32'h41, 32'h0);                   // sets err before reset
    chk("err_pre", {31'd0, err}, 32'h1);
    @(negedge clk);
    reset = 1'b1; DM_CS = 1'b1; DM_R = 1'b0; DM_W = 1'b1;
    maddr = 32'h40; mwdata = 32'h55;
    @(posedge clk);
    #1;
    DM_CS = 1'b0; DM_W = 1'b0;
    reset = 1'b0;
    chk("rst2_led", {24'd0, led_out}, 32'h0);
    chk("rst2_err", {31'd0, err}, 32'h0);
    rd("rst2_cycle", A_CYCLE, 32'h0);
    rd("rst2_rdcnt", A_RDCNT, 32'h0);
    rd("rst2_wrcnt", A_WRCNT, 32'h0);
    rd("rst2_status", A_STATUS, 32'h0);
    rd("rst2_ledreg", A_LED, 32'h0);
    rd("rst2_r40", 32'h40, 32'h1234_5678);
    rd("rst2_r10", 32'h10, 32'hDEAD_BEEF);
    rd("rst2_rdcnt2", A_RDCNT, 32'd2);

    chk("sb_empty", 32'(exp_q.size()), 32'd0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  // Absolute time limit so the run always ends.
  initial begin
    #100000;
    $display("FAIL timeout: got=running exp=finished");
    $fatal(1, "timeout");
  end

endmodule
